// File: rtl/ro_display_top.sv
// Ring-oscillator display controller: measures ring_out frequency and stress time, shows either on a 4-digit 7-seg display.
// Latency: gate-end latch to display 1 cycle; input synchronisers add 2-3 cycles; seg/an/led0 are registered.
// Backpressure: none; free-running counters, the display refreshes continuously.
module ro_display_top #(
  parameter int GATE_CYCLES    = 50000,
  parameter int REFRESH_CYCLES = 50000,
  parameter int SEC_CYCLES     = 50000000
) (
  input  logic fpga_clk1,
  input  logic rst,
  input  logic Mode,
  input  logic Stress,
  input  logic ring_out,
  output logic seg0,
  output logic seg1,
  output logic seg2,
  output logic seg3,
  output logic seg4,
  output logic seg5,
  output logic seg6,
  output logic dp,
  output logic an0,
  output logic an1,
  output logic an2,
  output logic an3,
  output logic led0
);

  localparam int GW = (GATE_CYCLES    > 1) ? $clog2(GATE_CYCLES)    : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int SW = (SEC_CYCLES     > 1) ? $clog2(SEC_CYCLES)     : 1;

  localparam logic [GW-1:0] GATE_LAST    = GW'(GATE_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [SW-1:0] SEC_LAST     = SW'(SEC_CYCLES - 1);

  // synchroniser stages
  logic r_ring_s1, r_ring_s2, r_ring_s3;
  logic r_mode_s1, r_mode_s2;
  logic r_stress_s1, r_stress_s2;

  // measurement and timer state
  logic [GW-1:0] r_gate_cnt;
  logic [15:0]   r_edge_cnt;
  logic [15:0]   r_freq_latch;
  logic [SW-1:0] r_sec_pre;
  logic [15:0]   r_stress_sec;

  // display multiplexer state
  logic [RW-1:0] r_ref_cnt;
  logic [1:0]    r_dig;
  logic [6:0]    r_seg;   // {g,f,e,d,c,b,a}, active-low
  logic [3:0]    r_an;
  logic          r_led;

  logic          w_rise;
  logic          w_gate_end;
  logic [15:0]   w_edge_next;
  logic [15:0]   w_disp;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_dec;
  logic [3:0]    w_an_dec;

  // Bring the asynchronous ring and the slow user inputs into the clock domain.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      r_ring_s1   <= 1'b0;
      r_ring_s2   <= 1'b0;
      r_ring_s3   <= 1'b0;
      r_mode_s1   <= 1'b0;
      r_mode_s2   <= 1'b0;
      r_stress_s1 <= 1'b0;
      r_stress_s2 <= 1'b0;
    end else begin
      r_ring_s1   <= ring_out;
      r_ring_s2   <= r_ring_s1;
      r_ring_s3   <= r_ring_s2;
      r_mode_s1   <= Mode;
      r_mode_s2   <= r_mode_s1;
      r_stress_s1 <= Stress;
      r_stress_s2 <= r_stress_s1;
    end
  end

  assign w_rise     = r_ring_s2 & ~r_ring_s3;
  assign w_gate_end = (r_gate_cnt == GATE_LAST);
  // A rise on the gate-end cycle still belongs to the closing window.
  assign w_edge_next = (w_rise && (r_edge_cnt != 16'hFFFF)) ? r_edge_cnt + 16'd1 : r_edge_cnt;

  // Gate window timer plus saturating edge counter; latch the count at window end.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_freq_latch <= '0;
    end else begin
      r_gate_cnt <= w_gate_end ? '0 : r_gate_cnt + 1'b1;
      if (w_gate_end) begin
        r_freq_latch <= w_edge_next;
        r_edge_cnt   <= '0;
      end else begin
        r_edge_cnt <= w_edge_next;
      end
    end
  end

  // Stress seconds: prescaler and seconds counter both freeze while Stress is low.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      r_sec_pre    <= '0;
      r_stress_sec <= '0;
    end else if (r_stress_s2) begin
      if (r_sec_pre == SEC_LAST) begin
        r_sec_pre    <= '0;
        r_stress_sec <= r_stress_sec + 16'd1;
      end else begin
        r_sec_pre <= r_sec_pre + 1'b1;
      end
    end
  end

  // Digit refresh timer; advances the active digit at each terminal count.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_dig     <= 2'd0;
    end else if (r_ref_cnt == REFRESH_LAST) begin
      r_ref_cnt <= '0;
      r_dig     <= r_dig + 2'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign w_disp   = r_mode_s2 ? r_stress_sec : r_freq_latch;
  assign w_nib    = w_disp[{r_dig, 2'b00} +: 4];
  assign w_an_dec = ~(4'b0001 << r_dig);

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg_dec = 7'b1111111;
    case (w_nib)
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      4'hF: w_seg_dec = 7'b0001110;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

  // Register pad-facing outputs so they are glitch-free.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      r_seg <= 7'b1000000;
      r_an  <= 4'b1110;
      r_led <= 1'b0;
    end else begin
      r_seg <= w_seg_dec;
      r_an  <= w_an_dec;
      r_led <= r_stress_s2;
    end
  end

  assign seg0 = r_seg[0];
  assign seg1 = r_seg[1];
  assign seg2 = r_seg[2];
  assign seg3 = r_seg[3];
  assign seg4 = r_seg[4];
  assign seg5 = r_seg[5];
  assign seg6 = r_seg[6];
  assign dp   = 1'b1;
  assign an0  = r_an[0];
  assign an1  = r_an[1];
  assign an2  = r_an[2];
  assign an3  = r_an[3];
  assign led0 = r_led;

endmodule

// File: tb/tb_ro_display_top.sv
// Bench for ro_display_top with shortened gate/refresh/second periods.
// Expected digit patterns are queued per displayed value and matched against the scanning anodes.
module tb_ro_display_top;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, Mode, Stress, ring_out;
  logic ring_en;
  logic seg0, seg1, seg2, seg3, seg4, seg5, seg6, dp;
  logic an0, an1, an2, an3, led0;

  wire [6:0] seg_bus = {seg6, seg5, seg4, seg3, seg2, seg1, seg0};
  wire [3:0] an_bus  = {an3, an2, an1, an0};

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];   // {an pattern, seg pattern}

  ro_display_top #(
    .GATE_CYCLES(100),
    .REFRESH_CYCLES(4),
    .SEC_CYCLES(10)
  ) dut (
    .fpga_clk1(clk), .rst(rst), .Mode(Mode), .Stress(Stress), .ring_out(ring_out),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5), .seg6(seg6),
    .dp(dp), .an0(an0), .an1(an1), .an2(an2), .an3(an3), .led0(led0)
  );

  // Ring oscillator model: period 4 clocks (80 ns), edges on falling clock.
  initial begin
    int ph;
    ph = 0;
    ring_out = 1'b0;
    forever begin
      @(negedge clk);
      if (ring_en) begin
        ph = ph + 1;
        if (ph == 2) begin
          ring_out = ~ring_out;
          ph = 0;
        end
      end else begin
        ring_out = 1'b0;
        ph = 0;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000; 4'h1: s = 7'b1111001; 4'h2: s = 7'b0100100; 4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001; 4'h5: s = 7'b0010010; 4'h6: s = 7'b0000010; 4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000; 4'h9: s = 7'b0010000; 4'hA: s = 7'b0001000; 4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110; 4'hD: s = 7'b0100001; 4'hE: s = 7'b0000110; default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic push_value(input logic [15:0] v);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] a;
      logic [3:0] nib;
      a   = 4'b0001 << d;
      a   = ~a;
      nib = v[4*d +: 4];
      exp_q.push_back({a, hex7(nib)});
    end
  endtask

  // Pop each expected digit, wait (bounded) for its anode, then compare segments.
  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      logic [10:0] item;
      bit found;
      item = exp_q.pop_front();
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge clk);
        if (an_bus === item[10:7]) found = 1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s: anode %b never seen, last an=%b", name, item[10:7], an_bus);
      end else if (seg_bus !== item[6:0] || dp !== 1'b1) begin
        errors++;
        $display("FAIL %s: an=%b seg=%b dp=%b, expected seg=%b dp=1", name, an_bus, seg_bus, dp, item[6:0]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (an_bus !== 4'b1110 || seg_bus !== 7'b1000000 || dp !== 1'b1 || led0 !== 1'b0) begin
      errors++;
      $display("FAIL %s: an=%b seg=%b dp=%b led0=%b, expected an=1110 seg=1000000 dp=1 led0=0",
               name, an_bus, seg_bus, dp, led0);
    end
  endtask

  // Check the currently lit digit shows the right nibble of v.
  task automatic check_current_digit(input string name, input logic [15:0] v);
    bit ok;
    logic [6:0] want;
    ok = 0;
    want = 7'bxxxxxxx;
    for (int d = 0; d < 4; d++) begin
      logic [3:0] a;
      a = 4'b0001 << d;
      a = ~a;
      if (an_bus === a) begin
        ok = 1;
        want = hex7(v[4*d +: 4]);
      end
    end
    checks++;
    if (!ok || seg_bus !== want) begin
      errors++;
      $display("FAIL %s: an=%b seg=%b, expected seg=%b for value %h", name, an_bus, seg_bus, want, v);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; Mode = 1'b0; Stress = 1'b0; ring_en = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
  endtask

  task automatic test_freq();
    ring_en = 1'b1;
    repeat (250) @(negedge clk);
    push_value(16'h0019);
    drain("freq_0019");
  endtask

  task automatic test_static_zero();
    ring_en = 1'b0;
    repeat (250) @(negedge clk);
    push_value(16'h0000);
    drain("freq_static_zero");
  endtask

  task automatic test_stress();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    Mode = 1'b1;
    Stress = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (i == 20) begin
        checks++;
        if (led0 !== 1'b1) begin
          errors++;
          $display("FAIL stress_led_on: led0=%b expected 1", led0);
        end
      end
    end
    Stress = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (led0 !== 1'b0) begin
      errors++;
      $display("FAIL stress_led_off: led0=%b expected 0", led0);
    end
    push_value(16'h0003);
    drain("stress_0003");
    repeat (30) @(negedge clk);
    push_value(16'h0003);
    drain("stress_hold");
    Stress = 1'b1;
    repeat (5) @(negedge clk);
    Stress = 1'b0;
    repeat (5) @(negedge clk);
    push_value(16'h0004);
    drain("stress_resume_0004");
  endtask

  task automatic test_mode_toggle();
    Mode = 1'b0;
    ring_en = 1'b1;
    repeat (250) @(negedge clk);
    push_value(16'h0019);
    drain("mode0_freq");
    Mode = 1'b1;
    repeat (3) @(negedge clk);
    check_current_digit("mode_switch_to_stress", 16'h0004);
    repeat (5) @(negedge clk);
    Mode = 1'b0;
    repeat (3) @(negedge clk);
    check_current_digit("mode_switch_to_freq", 16'h0019);
    push_value(16'h0019);
    drain("mode_freq_undisturbed");
    Mode = 1'b1;
    push_value(16'h0004);
    drain("mode_stress_undisturbed");
  endtask

  task automatic test_reset_mid();
    Mode = 1'b0;
    Stress = 1'b1;
    repeat (47) @(negedge clk);
    rst = 1'b1;
    Stress = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_outputs");
    rst = 1'b0;
    Mode = 1'b1;
    repeat (5) @(negedge clk);
    push_value(16'h0000);
    drain("reset_stress_cleared");
    Mode = 1'b0;
    push_value(16'h0000);
    drain("reset_freq_cleared");
    repeat (250) @(negedge clk);
    push_value(16'h0019);
    drain("freq_restart");
  endtask

  initial begin
    rst = 1'b1; Mode = 1'b0; Stress = 1'b0; ring_en = 1'b0;
    test_reset();
    test_freq();
    test_static_zero();
    test_stress();
    test_mode_toggle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
